// File: rtl/uart_byte_fifo_sequencer_if.sv
// uart_byte_fifo_sequencer_if: RX strobe in, TX launch/handshake, and FIFO status bundle
interface uart_byte_fifo_sequencer_if #(parameter int ADDR_W = 4);
  logic i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic i_TX_Active;
  logic i_TX_Done;
  logic o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic [7:0] o_Last_Byte;
  logic [ADDR_W:0] o_Count;
  logic o_Empty;
  logic o_Full;
  logic o_Overflow;
  modport slave (
    input i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done,
    output o_TX_DV, o_TX_Byte, o_Last_Byte, o_Count, o_Empty, o_Full, o_Overflow
  );
  modport master (
    output i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done,
    input o_TX_DV, o_TX_Byte, o_Last_Byte, o_Count, o_Empty, o_Full, o_Overflow
  );
endinterface

// File: rtl/uart_byte_fifo_sequencer.sv
// uart_byte_fifo_sequencer: buffers UART RX bytes and launches them one at a time into UART TX
module uart_byte_fifo_sequencer #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input logic i_Clk,
  input logic i_Rst,
  uart_byte_fifo_sequencer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT_DONE = 1'b1;
  logic [7:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [0:0] state_q, state_d;
  logic tx_dv_q, tx_dv_d, ovf_q, ovf_d;
  logic [7:0] tx_byte_q, tx_byte_d, last_q, last_d;
  logic empty, full, pop, push;
  assign empty = count_q == '0;
  assign full = count_q == (ADDR_W+1)'(DEPTH);
  // TX_Active gating also covers a transmitter still busy after this block is reset
  assign pop = state_q == IDLE && !empty && !bus.i_TX_Active;
  assign push = bus.i_RX_DV && (!full || pop);
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    state_d = state_q == IDLE ? (pop ? WAIT_DONE : IDLE) : (bus.i_TX_Done ? IDLE : WAIT_DONE);
    tx_dv_d = pop;
    tx_byte_d = pop ? mem_q[rd_ptr_q] : tx_byte_q;
    last_d = bus.i_RX_DV ? bus.i_RX_Byte : last_q;
    ovf_d = ovf_q | (bus.i_RX_DV && !push);
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      state_q <= IDLE;
      tx_dv_q <= 1'b0;
      tx_byte_q <= '0;
      last_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      state_q <= state_d;
      tx_dv_q <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_RX_Byte;
  end
  assign bus.o_TX_DV = tx_dv_q;
  assign bus.o_TX_Byte = tx_byte_q;
  assign bus.o_Last_Byte = last_q;
  assign bus.o_Count = count_q;
  assign bus.o_Empty = empty;
  assign bus.o_Full = full;
  assign bus.o_Overflow = ovf_q;
endmodule
